// File: rtl/tron_pkg.sv
// Shared tron video definitions: glyph codes, memory map, tile command format
// and the tile-map writer FSM state encoding.
package tron_pkg;

  localparam logic [15:0] GLYPH_BLACK             = 16'd0;
  localparam logic [15:0] GLYPH_BLUE              = 16'd1;
  localparam logic [15:0] GLYPH_YELLOW            = 16'd2;
  localparam logic [15:0] GLYPH_BLUE_PATH_FIRST   = 16'd4;
  localparam logic [15:0] GLYPH_BLUE_PATH_LAST    = 16'd6;
  localparam logic [15:0] GLYPH_BLUE_BIKE_A_FIRST = 16'd11;
  localparam logic [15:0] GLYPH_BLUE_BIKE_A_LAST  = 16'd19;
  localparam logic [15:0] GLYPH_BLUE_BIKE_B_FIRST = 16'd21;
  localparam logic [15:0] GLYPH_BLUE_BIKE_B_LAST  = 16'd29;
  localparam logic [15:0] GLYPH_YEL_PATH_FIRST    = 16'd34;
  localparam logic [15:0] GLYPH_YEL_PATH_LAST     = 16'd36;
  localparam logic [15:0] GLYPH_YEL_BIKE_A_FIRST  = 16'd41;
  localparam logic [15:0] GLYPH_YEL_BIKE_A_LAST   = 16'd49;
  localparam logic [15:0] GLYPH_YEL_BIKE_B_FIRST  = 16'd51;
  localparam logic [15:0] GLYPH_YEL_BIKE_B_LAST   = 16'd59;

  localparam logic [15:0] TILE_MAP_BASE  = 16'd40000;
  localparam logic [15:0] GLYPH_ROM_BASE = 16'd60000;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  localparam int CMD_W = 33;

  typedef struct packed {
    logic        op;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] glyph;
  } tile_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } wr_state_e;

  // Word address of tile (x, y); wraps mod 2^16 like the memory bus.
  function automatic logic [15:0] tile_addr(input logic [15:0] base,
                                            input logic [15:0] stride,
                                            input logic [7:0]  x,
                                            input logic [7:0]  y);
    return base + ({8'd0, y} * stride) + {8'd0, x};
  endfunction

endpackage

// File: rtl/tile_map_writer_if.sv
// Command and memory-write bundle between the game FSM, the tile-map writer
// and the shared video memory.
interface tile_map_writer_if;
  // cmd_*: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // the master holds the fields stable while cmd_valid is high and not accepted.
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [15:0] cmd_glyph;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

  modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_glyph,
                  input  cmd_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_glyph,
                  output cmd_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/tile_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry one wrap bit.
module tile_cmd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push is refused while full even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/tile_map_writer.sv
// Tile-map writer: buffers tile writes / full-map clears and drives the memory
// write port. Define TILE_MAP_WRITER_BLANK_GATE_EN to restrict writes to blanking.
module tile_map_writer
  import tron_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'd40000,
  parameter int          GRID_W     = 160,
  parameter int          GRID_H     = 120,
  parameter int          ROW_STRIDE = 160,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bright,
  tile_map_writer_if.slave bus,
  output logic             busy,
  output logic             err,
  output wr_state_e        state_dbg
);
  localparam logic [7:0]  X_LAST   = 8'(GRID_W - 1);
  localparam logic [7:0]  Y_LAST   = 8'(GRID_H - 1);
  localparam logic [15:0] STRIDE16 = 16'(ROW_STRIDE);

  wr_state_e         state, state_nx;
  tile_cmd_t         head;
  logic [CMD_W-1:0]  head_raw;
  logic              empty, full, pop;
  logic              in_range, last_tile, wr_ok;
  logic              we_nx, err_nx;
  logic [7:0]        cur_x, cur_y;
  logic [15:0]       cur_addr, row_addr, cur_glyph;

  tile_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .din   ({bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_glyph}),
    .pop   (pop),
    .dout  (head_raw),
    .full  (full),
    .empty (empty)
  );

  assign head = tile_cmd_t'(head_raw);

`ifdef TILE_MAP_WRITER_BLANK_GATE_EN
  assign wr_ok = !bright;
`else
  logic unused_bright;
  assign unused_bright = bright;
  assign wr_ok         = 1'b1;
`endif

  assign in_range  = (head.x <= X_LAST) && (head.y <= Y_LAST);
  assign last_tile = (cur_x == X_LAST) && (cur_y == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.op == OP_CLEAR) state_nx = ST_CLEAR;
          else if (in_range)       state_nx = ST_WRITE;
        end
      end
      ST_WRITE: if (wr_ok)              state_nx = ST_IDLE;
      ST_CLEAR: if (wr_ok && last_tile) state_nx = ST_IDLE;
      default:                          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    we_nx  = 1'b0;
    err_nx = 1'b0;
    case (state)
      ST_IDLE:            err_nx = !empty && (head.op == OP_WRITE) && !in_range;
      ST_WRITE, ST_CLEAR: we_nx  = wr_ok;
      default: ;
    endcase
  end

  // Registered memory port; address/data hold their last written value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= we_nx;
      err        <= err_nx;
      if (we_nx) begin
        bus.mem_addr  <= cur_addr;
        bus.mem_wdata <= cur_glyph;
      end
    end
  end

  // Position tracking: row_addr follows the start of the current row so the
  // row stride need not equal the grid width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x     <= '0;
      cur_y     <= '0;
      cur_addr  <= '0;
      row_addr  <= '0;
      cur_glyph <= '0;
    end else if (state == ST_IDLE && !empty) begin
      cur_glyph <= head.glyph;
      if (head.op == OP_CLEAR) begin
        cur_x    <= '0;
        cur_y    <= '0;
        cur_addr <= BASE_ADDR;
        row_addr <= BASE_ADDR;
      end else begin
        cur_x    <= head.x;
        cur_y    <= head.y;
        cur_addr <= tile_addr(BASE_ADDR, STRIDE16, head.x, head.y);
      end
    end else if (state == ST_CLEAR && wr_ok) begin
      if (cur_x == X_LAST) begin
        cur_x    <= '0;
        cur_y    <= cur_y + 8'd1;
        cur_addr <= row_addr + STRIDE16;
        row_addr <= row_addr + STRIDE16;
      end else begin
        cur_x    <= cur_x + 8'd1;
        cur_addr <= cur_addr + 16'd1;
      end
    end
  end

  assign bus.cmd_ready = !full;
  assign busy          = (state != ST_IDLE) || !empty;
  assign state_dbg     = state;
endmodule

// File: doc/tile_map_writer.md
Name: tile_map_writer

Overview:
- Write-side counterpart to the pixel generator that reads the tile map.
- Accepts tile-update commands from game logic: single-tile writes or a full-map clear. Buffers them in a small FIFO.
- Drives the tile-map memory write port, one word per cycle. Writes occur only while the display is in blanking, so the reader never sees a torn tile.
- Sits between the game FSM and the shared video memory.

Parameters:
- BASE_ADDR, 16'd40000, word address of tile (0,0).
- GRID_W, 160, tiles per row (x range 0..GRID_W-1).
- GRID_H, 120, tile rows (y range 0..GRID_H-1).
- ROW_STRIDE, 160, address step between rows.
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bright  in  1  from VGA timing; 1 = active video, 0 = blanking
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_op  in  1  0 = single write, 1 = clear whole map
- cmd_x  in  8  tile column (ignored for clear)
- cmd_y  in  8  tile row (ignored for clear)
- cmd_glyph  in  16  glyph code to store
- mem_we  out  1  write strobe to tile-map memory
- mem_addr  out  16  write word address
- mem_wdata  out  16  write data (glyph code)
- busy  out  1  FIFO non-empty or a command in progress
- err  out  1  one-cycle pulse: out-of-range single write dropped

Behaviour:
- Reset, asynchronous, active-high; all take effect immediately:
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, err = 0, busy = 0.
  - FIFO emptied; state = IDLE.
  - cmd_ready = 1 after reset deasserts.
  - A clear in progress is aborted; its remaining tiles are not written.
- Handshake:
  - A command is pushed on a rising clk edge with cmd_valid && cmd_ready.
  - No push when full, even if a pop occurs in the same cycle.
  - Commands execute strictly in push order.
- Address: mem_addr = BASE_ADDR + y*ROW_STRIDE + x, computed at 16 bits and truncated mod 2^16.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE:
  - If the FIFO is non-empty, pop the head and register address/data.
  - Out-of-range single write (x >= GRID_W or y >= GRID_H): pulse err for 1 cycle, discard the command, stay IDLE.
  - Valid single write: go to WRITE.
  - cmd_op = 1: load x = 0, y = 0, glyph; go to CLEAR.
- WRITE:
  - mem_we = 1 for exactly one cycle, on the first cycle with bright == 0.
  - Then go to IDLE.
- CLEAR:
  - Each cycle with bright == 0: mem_we = 1 at the current tile, then advance x.
  - x wraps at GRID_W-1 to 0 and y increments.
  - After tile (GRID_W-1, GRID_H-1) is written, go to IDLE.
  - While bright == 1: pause, mem_we = 0, position held.
  - Total GRID_W*GRID_H writes; default last address is 59199.
- Outputs are registered. mem_we never asserts while bright == 1, sampled in the same cycle.
- Latency with bright = 0: command pushed at edge t, mem_we high in cycle t+2.
- Back-to-back writes: one per 2 cycles (pop, then write).
- busy = (state != IDLE) || !empty.

Optional Feature:
- Macro: TILE_MAP_WRITER_BLANK_GATE_EN.
- Defined: writes are gated to bright == 0, as described above.
- Undefined: the bright input is ignored for gating; WRITE and CLEAR write every cycle (clear completes in GRID_W*GRID_H cycles). Intended for simulation and bring-up only.

Decomposition:
- Shared package tron_pkg holds:
  - glyph code constants (0 black, 1 blue, 2 yellow, 4..6 blue paths, 11..19 and 21..29 blue bike, 34..36 yellow paths, 41..49 and 51..59 yellow bike);
  - TILE_MAP_BASE = 40000 and GLYPH_ROM_BASE = 60000;
  - command op encoding OP_WRITE = 0, OP_CLEAR = 1.
- One sub-module: tile_cmd_fifo, a synchronous FIFO of width 33 (op + x + y + glyph) with full/empty flags and asynchronous reset.

Test Plan:
- bright = 0; push write (x=3, y=2, glyph=5) -> single mem_we pulse at cycle t+2, mem_addr = 40323, mem_wdata = 5.
- bright = 1 held 10 cycles; push write (0,0,1) -> no mem_we; then bright = 0 -> mem_we next cycle, addr 40000, data 1.
- Push write (160,0,2) -> err pulses 1 cycle, no mem_we, busy returns low; following write (159,119,2) -> addr 59199.
- Push clear glyph 0 with bright toggling every 50 cycles -> exactly 19200 writes, addresses 40000..59199 ascending with none skipped, mem_we only in blanking cycles.
- During clear, push 4 writes then attempt a 5th -> cmd_ready = 0 on the 5th; the 4 writes execute after the clear, in order.
- Assert rst mid-clear -> mem_we drops immediately, no further writes, busy = 0, FIFO empty, cmd_ready = 1 after release.
